// File: rtl/matmul_pkg.sv
// Shared state encoding, default sizes and index helpers for matmul_tile_engine.
// MATMUL_SAT_EN adds the saturating-accumulate helper.
package matmul_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, COMPUTE, DONE} state_e;

    localparam int DEF_N    = 16;
    localparam int DEF_TILE = 4;
    localparam int DEF_DW   = 16;
    localparam int DEF_ACCW = 40;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

`ifdef MATMUL_SAT_EN
    localparam int SAT_W = 65;

    // Clamp to the signed accw-bit range; callers compare input and result to detect a clip.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] sum,
                                                         input int accw);
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        one = SAT_W'(1);
        hi  = (one <<< (accw - 1)) - one;
        lo  = -(one <<< (accw - 1));
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction
`endif
endpackage

// File: rtl/mac_tile.sv
// TILE x TILE array of signed MACs performing one k-step of the tiled product.
// Under MATMUL_SAT_EN each accumulate saturates and clip_o reports any clip.
module mac_tile
    import matmul_pkg::*;
#(
    parameter int TILE = DEF_TILE,
    parameter int DW   = DEF_DW,
    parameter int ACCW = DEF_ACCW
) (
    input  logic                   clear_i,
    input  logic signed [DW-1:0]   a_col_i [TILE],
    input  logic signed [DW-1:0]   b_row_i [TILE],
    input  logic signed [ACCW-1:0] acc_i   [TILE][TILE],
    output logic signed [ACCW-1:0] acc_o   [TILE][TILE]
`ifdef MATMUL_SAT_EN
    ,
    output logic                   clip_o
`endif
);
    localparam int PW = 2 * DW;

`ifdef MATMUL_SAT_EN
    logic [TILE*TILE-1:0] clip_v;
    assign clip_o = |clip_v;
`endif

    for (genvar i = 0; i < TILE; i++) begin : g_row
        for (genvar j = 0; j < TILE; j++) begin : g_col
            logic signed [PW-1:0]   prod;
            logic signed [ACCW-1:0] base;

            assign prod = PW'(a_col_i[i]) * PW'(b_row_i[j]);
            // clear_i starts the element from zero instead of the stored sum.
            assign base = clear_i ? '0 : acc_i[i][j];
`ifdef MATMUL_SAT_EN
            logic signed [SAT_W-1:0] sum;
            logic signed [SAT_W-1:0] sat;
            assign sum               = SAT_W'(base) + SAT_W'(prod);
            assign sat               = saturate(sum, ACCW);
            assign clip_v[i*TILE+j]  = (sat != sum);
            assign acc_o[i][j]       = sat[ACCW-1:0];
`else
            assign acc_o[i][j] = base + ACCW'(prod);
`endif
        end
    end
endmodule

// File: rtl/matmul_tile_engine.sv
// Tiled signed matrix-multiply engine: C = A x B with word-write load and registered read-back.
// Define MATMUL_SAT_EN for saturating accumulation and the sticky sat_flag output.
module matmul_tile_engine
    import matmul_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int TILE = DEF_TILE,
    parameter int DW   = DEF_DW,
    parameter int ACCW = DEF_ACCW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [idx_w(N)-1:0]    wr_row,
    input  logic [idx_w(N)-1:0]    wr_col,
    input  logic signed [DW-1:0]   wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   rd_en,
    input  logic [idx_w(N)-1:0]    rd_row,
    input  logic [idx_w(N)-1:0]    rd_col,
    output logic signed [ACCW-1:0] rd_data,
    output logic                   rd_valid,
    output logic [31:0]            cycle_count
`ifdef MATMUL_SAT_EN
    ,
    output logic                   sat_flag
`endif
);
    localparam int IW     = idx_w(N);
    localparam int TW     = idx_w(TILE);
    localparam int T_LAST = N - TILE;

    if (N % TILE != 0) begin : g_bad_tile
        $error("matmul_tile_engine: N must be a multiple of TILE");
    end
    if (ACCW < 2 * DW) begin : g_bad_accw
        $error("matmul_tile_engine: ACCW must be at least 2*DW");
    end
`ifdef MATMUL_SAT_EN
    if (ACCW > SAT_W - 1) begin : g_bad_sat
        $error("matmul_tile_engine: ACCW too wide for the saturation helper");
    end
`endif

    logic signed [DW-1:0]   a_q [N][N];
    logic signed [DW-1:0]   b_q [N][N];
    logic signed [ACCW-1:0] c_q [N][N];

    state_e                 state_q;
    logic [IW-1:0]          tr_q, tc_q, k_q;
    logic [31:0]            cyc_q;
    logic                   busy_q, done_q, rd_valid_q;
    logic signed [ACCW-1:0] rd_data_q;

    logic signed [DW-1:0]   a_col   [TILE];
    logic signed [DW-1:0]   b_row   [TILE];
    logic signed [ACCW-1:0] acc_in  [TILE][TILE];
    logic signed [ACCW-1:0] acc_out [TILE][TILE];

    for (genvar i = 0; i < TILE; i++) begin : g_gather
        assign a_col[i] = a_q[tr_q + IW'(i)][k_q];
        assign b_row[i] = b_q[k_q][tc_q + IW'(i)];
        for (genvar j = 0; j < TILE; j++) begin : g_acc
            assign acc_in[i][j] = c_q[tr_q + IW'(i)][tc_q + IW'(j)];
        end
    end

`ifdef MATMUL_SAT_EN
    logic sat_q;
    logic clip;
    assign sat_flag = sat_q;
`endif

    mac_tile #(
        .TILE (TILE),
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clear_i (k_q == '0),
        .a_col_i (a_col),
        .b_row_i (b_row),
        .acc_i   (acc_in),
        .acc_o   (acc_out)
`ifdef MATMUL_SAT_EN
        ,
        .clip_o  (clip)
`endif
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tr_q    <= '0;
            tc_q    <= '0;
            k_q     <= '0;
            cyc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MATMUL_SAT_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    tr_q    <= '0;
                    tc_q    <= '0;
                    k_q     <= '0;
                    cyc_q   <= '0;
`ifdef MATMUL_SAT_EN
                    sat_q   <= 1'b0;
`endif
                    state_q <= COMPUTE;
                end
                COMPUTE: begin
                    cyc_q <= cyc_q + 32'd1;
`ifdef MATMUL_SAT_EN
                    sat_q <= sat_q | clip;
`endif
                    if (k_q == IW'(N - 1)) begin
                        k_q <= '0;
                        if (tc_q == IW'(T_LAST)) begin
                            tc_q <= '0;
                            if (tr_q == IW'(T_LAST)) begin
                                tr_q    <= '0;
                                state_q <= DONE;
                            end else begin
                                tr_q <= tr_q + IW'(TILE);
                            end
                        end else begin
                            tc_q <= tc_q + IW'(TILE);
                        end
                    end else begin
                        k_q <= k_q + IW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: operand and result arrays carry no reset; C is zeroed by the CLEAR state instead.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && wr_en) begin
            if (wr_sel) b_q[wr_row][wr_col] <= wr_data;
            else        a_q[wr_row][wr_col] <= wr_data;
        end
        if (state_q == CLEAR) begin
            c_q <= '{default: '0};
        end else if (state_q == COMPUTE) begin
            for (int i = 0; i < TILE; i++) begin
                for (int j = 0; j < TILE; j++) begin
                    c_q[tr_q + IW'(i)][tc_q + IW'(j)] <= acc_out[TW'(i)][TW'(j)];
                end
            end
        end
    end

    // The read samples C before this edge's MAC update lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= c_q[rd_row][rd_col];
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign cycle_count = cyc_q;
endmodule

// File: tb/tb_matmul_tile_engine.sv
// Directed self-checking bench for matmul_tile_engine with a read-back scoreboard.
// Connects sat_flag when MATMUL_SAT_EN is defined.
module tb_matmul_tile_engine;
    localparam int N       = 16;
    localparam int TILE    = 4;
    localparam int DW      = 16;
    localparam int ACCW    = 40;
    localparam int IW      = $clog2(N);
    localparam int EXP_CYC = (N / TILE) * (N / TILE) * N;
    localparam int EXP_LAT = EXP_CYC + 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   wr_en, wr_sel, start, rd_en;
    logic [IW-1:0]          wr_row, wr_col, rd_row, rd_col;
    logic signed [DW-1:0]   wr_data;
    logic                   busy, done, rd_valid;
    logic signed [ACCW-1:0] rd_data;
    logic [31:0]            cycle_count;
`ifdef MATMUL_SAT_EN
    logic                   sat_flag;
`endif

    always #5 clk = ~clk;

    matmul_tile_engine #(
        .N (N), .TILE (TILE), .DW (DW), .ACCW (ACCW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_col      (rd_col),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .cycle_count (cycle_count)
`ifdef MATMUL_SAT_EN
        ,
        .sat_flag    (sat_flag)
`endif
    );

    longint                 a_m [N][N];
    longint                 b_m [N][N];
    logic signed [ACCW-1:0] sb  [$];
    int                     checks = 0;
    int                     errors = 0;
    int                     n_done;
    logic signed [DW-1:0]   rv;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_op(input bit sel, input int row, input int col, input longint val);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_row  = IW'(row);
        wr_col  = IW'(col);
        wr_data = DW'(val);
        if (sel) b_m[row][col] = val;
        else     a_m[row][col] = val;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Launch a run; a stray start and a stray A write are injected mid-run and must be ignored.
    task automatic run(input string tag, input bit do_wr, input int row, input int col,
                       input longint val);
        int cyc, done_at, nd;
        start = 1'b1;
        if (do_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_row = IW'(row); wr_col = IW'(col); wr_data = DW'(val);
            a_m[row][col] = val;
        end
        @(posedge clk); #1;
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, "/busy_rise"}, {63'b0, busy}, 64'd1);
        cyc = 0; done_at = -1; nd = 0;
        while (cyc < EXP_LAT + 40 && (done_at < 0 || cyc < done_at + 4)) begin
            start   = (cyc == 50);
            wr_en   = (cyc == 60);
            wr_sel  = 1'b0;
            wr_row  = '0;
            wr_col  = '0;
            wr_data = 16'sd99;
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                nd++;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc == EXP_LAT - 1) check({tag, "/busy_in_done"}, {63'b0, busy}, 64'd1);
        end
        start = 1'b0;
        wr_en = 1'b0;
        check({tag, "/done_latency"}, 64'(done_at), 64'(EXP_LAT));
        check({tag, "/done_pulses"}, 64'(nd), 64'd1);
        check({tag, "/busy_fall"}, {63'b0, busy}, 64'd0);
        check({tag, "/cycle_count"}, {32'b0, cycle_count}, 64'(EXP_CYC));
    endtask

    task automatic readback(input string tag);
        longint                 s;
        logic signed [ACCW-1:0] e;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += a_m[r][k] * b_m[k][c];
                e      = s[ACCW-1:0];
                rd_en  = 1'b1;
                rd_row = IW'(r);
                rd_col = IW'(c);
                sb.push_back(e);
                @(posedge clk); #1;
                if (rd_valid === 1'b1 && sb.size() != 0)
                    check($sformatf("%s C[%0d][%0d]", tag, r, c), rd_data, sb.pop_front());
                else
                    check({tag, "/rd_valid"}, {63'b0, rd_valid}, 64'd1);
            end
        end
        rd_en = 1'b0;
        @(posedge clk); #1;
        check({tag, "/rd_valid_drop"}, {63'b0, rd_valid}, 64'd0);
        check({tag, "/sb_empty"}, 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0; rd_en = 1'b0;
        wr_row = '0; wr_col = '0; rd_row = '0; rd_col = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst/busy", {63'b0, busy}, 64'd0);
        check("rst/done", {63'b0, done}, 64'd0);
        check("rst/rd_valid", {63'b0, rd_valid}, 64'd0);
        check("rst/rd_data", rd_data, 64'd0);
        check("rst/cycle_count", {32'b0, cycle_count}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity times an index matrix reproduces the index matrix.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_op(1'b0, r, c, (r == c) ? 1 : 0);
                write_op(1'b1, r, c, r * 16 + c);
            end
        run("ident", 1'b0, 0, 0, 0);
        readback("ident");

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_op(1'b0, r, c, 1);
                write_op(1'b1, r, c, 1);
            end
        run("ones", 1'b0, 0, 0, 0);
        readback("ones");

        // Reloading B must not leave any of the previous run's sums behind.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) write_op(1'b1, r, c, 2);
        run("twos", 1'b0, 0, 0, 0);
        readback("twos");

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                write_op(1'b0, r, c, -32768);
                write_op(1'b1, r, c, -32768);
            end
        run("ext", 1'b0, 0, 0, 0);
        readback("ext");
`ifdef MATMUL_SAT_EN
        check("ext/sat_flag", {63'b0, sat_flag}, 64'd0);
`endif

        // Reset at cycle 100 of a run: no done pulse, then a clean rerun on the retained operands.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst/busy", {63'b0, busy}, 64'd0);
        check("midrst/done", {63'b0, done}, 64'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        n_done = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done === 1'b1) n_done++;
        end
        check("midrst/no_done", 64'(n_done), 64'd0);
        check("midrst/busy_idle", {63'b0, busy}, 64'd0);
        check("midrst/cycle_count", {32'b0, cycle_count}, 64'd0);
        run("rerun", 1'b0, 0, 0, 0);
        readback("rerun");

        // Random operands; a write issued together with start must be used by that run.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                rv = DW'($urandom);
                write_op(1'b0, r, c, longint'(rv));
                rv = DW'($urandom);
                write_op(1'b1, r, c, longint'(rv));
            end
        run("rand", 1'b1, N - 1, N - 1, 1234);
        readback("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
